// File: rtl/stage_mux.sv
// Purpose: selects one of N packed data channels and registers it behind a two-entry (OUT + SKID) valid/ready stage.
// Latency: 1 cycle from input acceptance to data_o when OUT is empty or draining.
// Backpressure: ready_o is registered (NOT skid-valid) and never depends combinationally on ready_i or valid_i.
module stage_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [N*WIDTH-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               err_o
);

    // Occupancy of the stage: OUT only, or OUT plus SKID.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   out_dat;
    logic               out_err;
    logic [WIDTH-1:0]   skid_dat;
    logic               skid_err;
    logic [WIDTH-1:0]   cap_dat;
    logic               cap_err;
    logic               in_xfer;

    // Only a FULL stage refuses beats; reset also holds ready low while asserted.
    assign ready_o = (state != FULL) && !rst_i;
    assign in_xfer = valid_i && ready_o;
    assign valid_o = (state != EMPTY);
    assign data_o  = out_dat;
    assign err_o   = out_err;

    // Channel select: an out-of-range select yields zero data tagged as an error.
    always_comb begin
        cap_dat = '0;
        cap_err = (int'(sel_i) >= N);
        for (int k = 0; k < N; k++) begin
            if (sel_i == SEL_W'(k)) begin
                cap_dat = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy next-state: flush empties everything, otherwise follow the transfers.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) state_nxt = ONE;
                ONE: begin
                    if (ready_i && !in_xfer) state_nxt = EMPTY;
                    else if (!ready_i && in_xfer) state_nxt = FULL;
                end
                FULL: if (ready_i) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Data/err payload: load OUT when it is empty or draining, park in SKID otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_dat  <= '0;
            out_err  <= 1'b0;
            skid_dat <= '0;
            skid_err <= 1'b0;
        end else if (flush_i) begin
            out_err  <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_dat <= cap_dat;
                        out_err <= cap_err;
                    end
                end
                ONE: begin
                    if (in_xfer && ready_i) begin
                        out_dat <= cap_dat;
                        out_err <= cap_err;
                    end else if (in_xfer) begin
                        skid_dat <= cap_dat;
                        skid_err <= cap_err;
                    end
                end
                FULL: begin
                    if (ready_i) begin
                        out_dat <= skid_dat;
                        out_err <= skid_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mux.sv
// Directed and randomized checks of stage_mux (N=4 main instance, N=3 instance for bad selects).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Random phase compares against a two-deep FIFO scoreboard.
module tb_stage_mux;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic         vin, rdy_o, rin, vout, err;
    logic [1:0]   sel;
    logic [127:0] din;
    logic [31:0]  dout;

    logic         vin3, rdy3, vout3, err3;
    logic [1:0]   sel3;
    logic [95:0]  din3;
    logic [31:0]  dout3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_mux #(.WIDTH(32), .N(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .valid_i(vin), .ready_o(rdy_o), .sel_i(sel), .data_i(din),
        .valid_o(vout), .ready_i(rin), .data_o(dout), .err_o(err)
    );

    stage_mux #(.WIDTH(32), .N(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .valid_i(vin3), .ready_o(rdy3), .sel_i(sel3), .data_i(din3),
        .valid_o(vout3), .ready_i(1'b1), .data_o(dout3), .err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] w;
    logic        hold_prev;
    logic [31:0] dout_prev;

    initial begin
        rst = 1'b1; flush = 1'b0; vin = 1'b0; rin = 1'b0; sel = '0; din = '0;
        vin3 = 1'b0; sel3 = '0; din3 = '0;
        step(); step();
        // reset state
        chk("rst_ready", {31'd0, rdy_o}, 32'd0);
        chk("rst_valid", {31'd0, vout}, 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, rdy_o}, 32'd1);

        // streaming, one beat per cycle
        din = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        rin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vin = 1'b1; sel = 2'(k);
            step();
            chk("stream_valid", {31'd0, vout}, 32'd1);
            chk("stream_data", dout, 32'hA000_0000 + 32'(k));
            chk("stream_err", {31'd0, err}, 32'd0);
            chk("stream_ready", {31'd0, rdy_o}, 32'd1);
        end
        vin = 1'b0;
        step();
        chk("stream_drain", {31'd0, vout}, 32'd0);

        // backpressure: 0x11 then 0x22 with ready_i low
        rin = 1'b0; sel = 2'd0; vin = 1'b1; din = {96'd0, 32'h11};
        step();
        chk("bp_one_data", dout, 32'h11);
        chk("bp_one_ready", {31'd0, rdy_o}, 32'd1);
        din = {96'd0, 32'h22};
        step();
        chk("bp_full_ready", {31'd0, rdy_o}, 32'd0);
        chk("bp_full_data", dout, 32'h11);
        vin = 1'b0; din = {96'd0, 32'h99};
        step();
        chk("bp_hold_valid", {31'd0, vout}, 32'd1);
        chk("bp_hold_data", dout, 32'h11);
        rin = 1'b1;
        step();
        chk("bp_second_data", dout, 32'h22);
        chk("bp_second_valid", {31'd0, vout}, 32'd1);
        chk("bp_ready_back", {31'd0, rdy_o}, 32'd1);
        step();
        chk("bp_empty", {31'd0, vout}, 32'd0);

        // flush while FULL with valid_i high
        rin = 1'b0; vin = 1'b1; din = {96'd0, 32'h33};
        step();
        din = {96'd0, 32'h44};
        step();
        chk("fl_full_ready", {31'd0, rdy_o}, 32'd0);
        din = {96'd0, 32'h55}; flush = 1'b1;
        step();
        flush = 1'b0; vin = 1'b0;
        chk("fl_valid", {31'd0, vout}, 32'd0);
        chk("fl_ready", {31'd0, rdy_o}, 32'd1);
        chk("fl_err", {31'd0, err}, 32'd0);
        rin = 1'b1;
        step();
        chk("fl_no_beat", {31'd0, vout}, 32'd0);

        // reset while FULL
        rin = 1'b0; vin = 1'b1; din = {96'd0, 32'h66};
        step();
        din = {96'd0, 32'h77};
        step();
        vin = 1'b0; rst = 1'b1;
        #1;
        chk("mrst_ready_during", {31'd0, rdy_o}, 32'd0);
        step();
        chk("mrst_valid", {31'd0, vout}, 32'd0);
        chk("mrst_data", dout, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_ready", {31'd0, rdy_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst_ready_after", {31'd0, rdy_o}, 32'd1);
        rin = 1'b1;
        step();
        chk("mrst_no_beat", {31'd0, vout}, 32'd0);

        // N=3 instance: out-of-range select
        din3 = {32'hC2, 32'hC1, 32'hC0};
        vin3 = 1'b1; sel3 = 2'd3;
        step();
        chk("bad_valid", {31'd0, vout3}, 32'd1);
        chk("bad_data", dout3, 32'd0);
        chk("bad_err", {31'd0, err3}, 32'd1);
        sel3 = 2'd1;
        step();
        chk("good_data", dout3, 32'hC1);
        chk("good_err", {31'd0, err3}, 32'd0);
        vin3 = 1'b0;
        step();
        chk("n3_drain", {31'd0, vout3}, 32'd0);

        // randomized traffic against a two-deep FIFO model
        hold_prev = 1'b0; dout_prev = '0;
        for (int c = 0; c < 10000; c++) begin
            vin = 1'($urandom_range(0, 1));
            rin = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            din = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("rnd_valid", {31'd0, vout}, {31'd0, (q.size() > 0)});
            chk("rnd_ready", {31'd0, rdy_o}, {31'd0, (q.size() < 2)});
            if (q.size() > 0) chk("rnd_data", dout, q[0]);
            if (hold_prev) chk("rnd_stable", dout, dout_prev);
            hold_prev = vout && !rin;
            dout_prev = dout;
            if (vout && rin && q.size() > 0) w = q.pop_front();
            if (vin && rdy_o) q.push_back(din[sel*32 +: 32]);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
